crc_seq_ctrl: RTL and testbench

CRC_SEQ_CTRL -- requirements
Module: crc_seq_ctrl

---
 rtl/crc_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_crc_seq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/crc_seq_ctrl.sv
// Sequencer that arbitrates two byte requesters, streams the granted byte
// LSB-first into a serial CRC block and collects its 8-bit result.
module crc_seq_ctrl #(
    parameter int TIMEOUT      = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ_A,
    input  logic       REQ_B,
    input  logic [7:0] DATA_A,
    input  logic [7:0] DATA_B,
    output logic       GNT_A,
    output logic       GNT_B,
    output logic       CRC_DATA,
    output logic       CRC_ACTIVE,
    output logic       CRC_RST_N,
    input  logic       CRC_IN,
    input  logic       CRC_VALID,
    output logic [7:0] CRC_OUT,
    output logic       OUT_VALID,
    output logic       OUT_SRC,
    output logic       BUSY,
    output logic       TIMEOUT_ERR
);

    localparam int CNT_MAX = (TIMEOUT > FLUSH_CYCLES) ? ((TIMEOUT > 8) ? TIMEOUT : 8)
                                                      : ((FLUSH_CYCLES > 8) ? FLUSH_CYCLES : 8);
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, FLUSH, SHIFT, WAIT, COLLECT, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      byte_q, byte_d;
    logic [7:0]      sr_q, sr_d;
    logic            src_q, src_d;
    logic            prio_b_q, prio_b_d;
    logic            pick_b;
    logic            gnt_a_d, gnt_b_d, crc_data_d, crc_active_d, crc_rst_n_d;
    logic [7:0]      crc_out_d;
    logic            out_valid_d, out_src_d, busy_d, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        byte_d        = byte_q;
        sr_d          = sr_q;
        src_d         = src_q;
        prio_b_d      = prio_b_q;
        pick_b        = 1'b0;
        gnt_a_d       = 1'b0;
        gnt_b_d       = 1'b0;
        crc_data_d    = 1'b0;
        crc_out_d     = CRC_OUT;
        out_valid_d   = 1'b0;
        out_src_d     = OUT_SRC;
        timeout_err_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (REQ_A || REQ_B) begin
                    pick_b   = REQ_B && (!REQ_A || prio_b_q);
                    byte_d   = pick_b ? DATA_B : DATA_A;
                    src_d    = pick_b;
                    prio_b_d = !pick_b;
                    gnt_a_d  = !pick_b;
                    gnt_b_d  = pick_b;
                    cnt_d    = '0;
                    state_d  = FLUSH;
                end
            end
            // The grant cycle leads in; FLUSH_CYCLES further cycles follow before SHIFT.
            FLUSH: begin
                if (cnt_q == CW'(FLUSH_CYCLES)) begin
                    state_d    = SHIFT;
                    cnt_d      = '0;
                    crc_data_d = byte_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CW'(7)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    crc_data_d = byte_q[cnt_q[2:0] + 3'd1];
                end
            end
            // A raised TIMEOUT_ERR marks an abort already signalled; leave on the next edge.
            WAIT: begin
                if (TIMEOUT_ERR) begin
                    state_d = IDLE;
                end else if (CRC_VALID) begin
                    sr_d[0] = CRC_IN;
                    cnt_d   = CW'(1);
                    state_d = COLLECT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(TIMEOUT - 2)) timeout_err_d = 1'b1;
                end
            end
            COLLECT: begin
                if (TIMEOUT_ERR) begin
                    state_d = IDLE;
                end else if (CRC_VALID) begin
                    sr_d[cnt_q[2:0]] = CRC_IN;
                    if (cnt_q == CW'(7)) begin
                        state_d     = DONE;
                        crc_out_d   = {CRC_IN, sr_q[6:0]};
                        out_valid_d = 1'b1;
                        out_src_d   = src_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    timeout_err_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        crc_active_d = (state_d == SHIFT);
        crc_rst_n_d  = !((state_d == IDLE) || (state_d == FLUSH));
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            byte_q      <= '0;
            sr_q        <= '0;
            src_q       <= 1'b0;
            prio_b_q    <= 1'b0;
            GNT_A       <= 1'b0;
            GNT_B       <= 1'b0;
            CRC_DATA    <= 1'b0;
            CRC_ACTIVE  <= 1'b0;
            CRC_RST_N   <= 1'b0;
            CRC_OUT     <= '0;
            OUT_VALID   <= 1'b0;
            OUT_SRC     <= 1'b0;
            BUSY        <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byte_q      <= byte_d;
            sr_q        <= sr_d;
            src_q       <= src_d;
            prio_b_q    <= prio_b_d;
            GNT_A       <= gnt_a_d;
            GNT_B       <= gnt_b_d;
            CRC_DATA    <= crc_data_d;
            CRC_ACTIVE  <= crc_active_d;
            CRC_RST_N   <= crc_rst_n_d;
            CRC_OUT     <= crc_out_d;
            OUT_VALID   <= out_valid_d;
            OUT_SRC     <= out_src_d;
            BUSY        <= busy_d;
            TIMEOUT_ERR <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// Directed plus randomized frames against a cycle-level model of the
// sequencer's visible timing, with a stub standing in for the CRC block.
module tb_crc_seq_ctrl;

    localparam int TIMEOUT      = 16;
    localparam int FLUSH_CYCLES = 2;
    localparam int M_OK = 0, M_NEVER = 1, M_DROP = 2;

    logic       CLK = 1'b0;
    logic       RST, REQ_A, REQ_B, CRC_IN, CRC_VALID;
    logic [7:0] DATA_A, DATA_B;
    logic       GNT_A, GNT_B, CRC_DATA, CRC_ACTIVE, CRC_RST_N;
    logic [7:0] CRC_OUT;
    logic       OUT_VALID, OUT_SRC, BUSY, TIMEOUT_ERR;

    crc_seq_ctrl #(.TIMEOUT(TIMEOUT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .CLK(CLK), .RST(RST), .REQ_A(REQ_A), .REQ_B(REQ_B),
        .DATA_A(DATA_A), .DATA_B(DATA_B), .GNT_A(GNT_A), .GNT_B(GNT_B),
        .CRC_DATA(CRC_DATA), .CRC_ACTIVE(CRC_ACTIVE), .CRC_RST_N(CRC_RST_N),
        .CRC_IN(CRC_IN), .CRC_VALID(CRC_VALID), .CRC_OUT(CRC_OUT),
        .OUT_VALID(OUT_VALID), .OUT_SRC(OUT_SRC), .BUSY(BUSY),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    int         tests = 0;
    int         fails = 0;
    logic       pend_a, pend_b;
    logic [7:0] dat_a, dat_b;
    logic       rr_b;
    logic [7:0] last_out;
    logic       obs_src;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_req(input logic b);
        if (b) begin
            if (!pend_b) begin pend_b = 1'b1; dat_b = 8'($urandom); end
            REQ_B = 1'b1; DATA_B = dat_b;
        end else begin
            if (!pend_a) begin pend_a = 1'b1; dat_a = 8'($urandom); end
            REQ_A = 1'b1; DATA_A = dat_a;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1; CRC_VALID = 1'b0; CRC_IN = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("rst_gnt", 32'({GNT_A, GNT_B}), 32'(0));
        check("rst_busy", 32'(BUSY), 32'(0));
        check("rst_rstn", 32'(CRC_RST_N), 32'(0));
        check("rst_active", 32'({CRC_ACTIVE, CRC_DATA}), 32'(0));
        check("rst_out", 32'(CRC_OUT), 32'(0));
        check("rst_flags", 32'({OUT_VALID, OUT_SRC, TIMEOUT_ERR}), 32'(0));
        RST = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0;
        pend_a = 1'b0; pend_b = 1'b0; rr_b = 1'b0; last_out = 8'h00;
    endtask

    // One full frame: grant, flush, LSB-first shift, stub response, result or abort.
    task automatic frame(input int mode, input int dly, input logic [7:0] crc);
        logic       pick_b;
        logic [7:0] bv;
        int         s7, exp_end, nbits, k, ov_n, terr_n;
        logic       done;
        if (!pend_a && !pend_b) add_req(1'($urandom_range(0, 1)));
        REQ_A = pend_a; REQ_B = pend_b; DATA_A = dat_a; DATA_B = dat_b;
        pick_b = pend_b && (!pend_a || rr_b);
        bv     = pick_b ? dat_b : dat_a;
        @(negedge CLK);
        check("gnt_a", 32'(GNT_A), 32'(!pick_b));
        check("gnt_b", 32'(GNT_B), 32'(pick_b));
        check("gnt_busy", 32'(BUSY), 32'(1));
        check("gnt_rstn", 32'(CRC_RST_N), 32'(0));
        rr_b = !pick_b;
        if (pick_b) begin pend_b = 1'b0; REQ_B = 1'b0; end
        else begin pend_a = 1'b0; REQ_A = 1'b0; end
        s7      = 11 + dly + 7;
        exp_end = (mode == M_OK) ? s7 + 2 : 11 + TIMEOUT;
        nbits   = (mode == M_OK) ? 8 : ((mode == M_DROP) ? 4 : 0);
        ov_n = 0; terr_n = 0; done = 1'b0;
        for (int t = 1; t <= 80 && !done; t++) begin
            @(negedge CLK);
            check("out_valid", 32'(OUT_VALID), 32'(mode == M_OK && t == s7 + 1));
            check("excl", 32'(OUT_VALID & TIMEOUT_ERR), 32'(0));
            if (OUT_VALID === 1'b1) begin
                ov_n++;
                obs_src = OUT_SRC;
                check("out_src", 32'(OUT_SRC), 32'(pick_b));
                check("crc_out", 32'(CRC_OUT), 32'(crc));
            end
            if (TIMEOUT_ERR === 1'b1) terr_n++;
            if (mode != M_DROP)
                check("timeout_err", 32'(TIMEOUT_ERR), 32'(mode == M_NEVER && t == 10 + TIMEOUT));
            if (BUSY !== 1'b1) begin
                done = 1'b1;
                if (mode != M_DROP) check("end_cycle", 32'(t), 32'(exp_end));
                check("idle_active", 32'({CRC_ACTIVE, CRC_DATA}), 32'(0));
                check("idle_rstn", 32'(CRC_RST_N), 32'(0));
            end else begin
                check("active", 32'(CRC_ACTIVE), 32'(t >= 3 && t <= 10));
                check("data", 32'(CRC_DATA), (t >= 3 && t <= 10) ? 32'(bv[t-3]) : 32'(0));
                check("rstn", 32'(CRC_RST_N), 32'(t >= FLUSH_CYCLES + 1));
                check("no_gnt", 32'({GNT_A, GNT_B}), 32'(0));
            end
            k = t - 11 - dly;
            CRC_VALID = (k >= 0 && k < nbits);
            CRC_IN    = CRC_VALID ? crc[k] : 1'b0;
            if (t == 5 && $urandom_range(0, 1) == 1) add_req(!pick_b);
        end
        CRC_VALID = 1'b0; CRC_IN = 1'b0;
        check("frame_done", 32'(done), 32'(1));
        check("ov_count", 32'(ov_n), 32'(mode == M_OK));
        check("terr_count", 32'(terr_n), 32'(mode != M_OK));
        if (mode == M_OK) last_out = crc;
        else check("out_hold", 32'(CRC_OUT), 32'(last_out));
    endtask

    initial begin
        logic [7:0] bv;
        RST = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0; DATA_A = 8'h00; DATA_B = 8'h00;
        CRC_IN = 1'b0; CRC_VALID = 1'b0; obs_src = 1'b0;
        pend_a = 1'b0; pend_b = 1'b0; dat_a = 8'h00; dat_b = 8'h00;
        rr_b = 1'b0; last_out = 8'h00;

        // Single requester A, byte 0x3C, stub returns 0xA5.
        do_reset();
        pend_a = 1'b1; dat_a = 8'h3C;
        frame(M_OK, 0, 8'hA5);
        check("src_a", 32'(obs_src), 32'(0));
        check("out_hold_a5", 32'(CRC_OUT), 32'(8'hA5));

        // Both requesting after reset: A, B, A, B.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            add_req(1'b0); add_req(1'b1);
            frame(M_OK, int'($urandom_range(0, 4)), 8'($urandom));
            check("rr_first", 32'(obs_src), 32'(0));
            frame(M_OK, int'($urandom_range(0, 4)), 8'($urandom));
            check("rr_second", 32'(obs_src), 32'(1));
        end

        // Stub silent: abort on the TIMEOUT-th WAIT cycle.
        frame(M_NEVER, 0, 8'h00);
        // Stub stops after four bits.
        frame(M_DROP, 1, 8'($urandom));

        // Reset during the 5th SHIFT cycle, then a tie goes to A.
        do_reset();
        add_req(1'b0);
        bv = dat_a;
        @(negedge CLK);
        check("mid_gnt", 32'(GNT_A), 32'(1));
        REQ_A = 1'b0; pend_a = 1'b0;
        repeat (7) @(negedge CLK);
        check("mid_active", 32'(CRC_ACTIVE), 32'(1));
        check("mid_data", 32'(CRC_DATA), 32'(bv[4]));
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_active", 32'(CRC_ACTIVE), 32'(0));
        check("mid_rst_rstn", 32'(CRC_RST_N), 32'(0));
        check("mid_rst_busy", 32'(BUSY), 32'(0));
        check("mid_rst_flags", 32'({OUT_VALID, TIMEOUT_ERR}), 32'(0));
        RST = 1'b0; rr_b = 1'b0; last_out = 8'h00;
        add_req(1'b0); add_req(1'b1);
        frame(M_OK, 2, 8'($urandom));
        check("mid_src", 32'(obs_src), 32'(0));

        // Randomized traffic and stub behaviour.
        for (int i = 0; i < 24; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) add_req(1'b0);
            if ($urandom_range(0, 1) == 1) add_req(1'b1);
            frame((r < 7) ? M_OK : ((r < 9) ? M_DROP : M_NEVER),
                  int'($urandom_range(0, 5)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
